// File: rtl/sprite_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sprite_pkg : renderer latency, default colours, rectangle record    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package sprite_pkg;
   import vga_pkg::*;

   localparam int          RENDER_LATENCY    = 2;
   localparam int          DEF_N_SPRITES     = 4;
   localparam logic [11:0] DEF_SPRITE_COLOR  = 12'hFFF;
   localparam logic [11:0] DEF_NET_COLOR     = 12'h888;

   typedef struct packed {
      logic [X_POS_W-1:0] x_pos;
      logic [Y_POS_W-1:0] y_pos;
      logic [X_POS_W-1:0] right;
      logic [Y_POS_W-1:0] bottom;
   } rect_t;
endpackage
`default_nettype wire

// File: rtl/vga_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_pkg : 640x480 screen geometry and pixel-counter widths          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package vga_pkg;
   localparam int SCREEN_H_RES = 640;
   localparam int SCREEN_V_RES = 480;
   localparam int X_POS_W      = 10;
   localparam int Y_POS_W      = 10;
endpackage
`default_nettype wire

// File: rtl/sprite_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sprite_if : one sprite rectangle, game logic -> renderer            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface sprite_if;
   import vga_pkg::*;

   logic [X_POS_W-1:0] x_pos;
   logic [Y_POS_W-1:0] y_pos;
   logic [X_POS_W-1:0] right;
   logic [Y_POS_W-1:0] bottom;

   modport game_mp   (output x_pos, y_pos, right, bottom);
   modport render_mp (input  x_pos, y_pos, right, bottom);
endinterface
`default_nettype wire

// File: rtl/sprite_hit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sprite_hit : registered point-in-rectangle test, [low, high) bounds |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sprite_hit
   import vga_pkg::*;
   import sprite_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [X_POS_W-1:0] x_i,
   input  logic [Y_POS_W-1:0] y_i,
   input  rect_t              rect_i,
   output logic               hit_o
);
   logic hit_d;
   logic hit_q;

   // Exclusive upper bounds make right <= x_pos or bottom <= y_pos an empty rectangle.
   always_comb begin
      hit_d = (x_i >= rect_i.x_pos) && (x_i < rect_i.right) &&
              (y_i >= rect_i.y_pos) && (y_i < rect_i.bottom);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) hit_q <= 1'b0;
      else       hit_q <= hit_d;
   end

   assign hit_o = hit_q;
endmodule
`default_nettype wire

// File: rtl/sprite_renderer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sprite_renderer : 2-stage sprite pixel pipeline with frame shadows  |
// | Optional macro CENTER_NET_EN draws the centre net.  Revision: 1.0  |
// +--------------------------------------------------------------------+
module sprite_renderer
   import vga_pkg::*;
   import sprite_pkg::*;
#(
   parameter int               RGB_W        = 12,
   parameter logic [RGB_W-1:0] SPRITE_COLOR = RGB_W'(DEF_SPRITE_COLOR),
   parameter logic [RGB_W-1:0] NET_COLOR    = RGB_W'(DEF_NET_COLOR),
   parameter int               N_SPRITES    = DEF_N_SPRITES
)(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [X_POS_W-1:0] x_pos_i,
   input  logic [Y_POS_W-1:0] y_pos_i,
   input  logic               display_on_i,
   input  logic               hsync_i,
   input  logic               vsync_i,
   sprite_if.render_mp        sprites_i [N_SPRITES],
   output logic [RGB_W-1:0]   rgb_o,
   output logic               hsync_o,
   output logic               vsync_o,
   output logic               new_frame_o
);
   logic                      load_w;
   logic [N_SPRITES-1:0]      hit_w;
   logic                      net_d;
   logic                      net_q;
   logic                      disp_q;
   logic [RENDER_LATENCY-1:0] hs_q;
   logic [RENDER_LATENCY-1:0] vs_q;
   logic [RGB_W-1:0]          rgb_d;
   logic [RGB_W-1:0]          rgb_q;

   // Shadows load one line after the strobe so game-logic writes have settled.
   assign load_w      = (y_pos_i == Y_POS_W'(SCREEN_V_RES + 1)) && (x_pos_i == '0);
   assign new_frame_o = !rst_i && (y_pos_i == Y_POS_W'(SCREEN_V_RES)) && (x_pos_i == '0);

   for (genvar g = 0; g < N_SPRITES; g++) begin : g_sprite
      rect_t shadow_q;

      always_ff @(posedge clk_i) begin
         if (rst_i)       shadow_q <= '0;
         else if (load_w) shadow_q <= '{sprites_i[g].x_pos, sprites_i[g].y_pos,
                                        sprites_i[g].right, sprites_i[g].bottom};
      end

      sprite_hit u_hit (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .x_i    (x_pos_i),
         .y_i    (y_pos_i),
         .rect_i (shadow_q),
         .hit_o  (hit_w[g])
      );
   end

`ifdef CENTER_NET_EN
   assign net_d = ((x_pos_i == X_POS_W'(SCREEN_H_RES/2 - 1)) ||
                   (x_pos_i == X_POS_W'(SCREEN_H_RES/2))) && !y_pos_i[3];
`else
   assign net_d = 1'b0;
`endif

   // Every sprite shares one colour, so an OR equals lowest-index priority.
   always_comb begin
      rgb_d = '0;
      if (disp_q) begin
         if (|hit_w)     rgb_d = SPRITE_COLOR;
         else if (net_q) rgb_d = NET_COLOR;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         disp_q <= 1'b0;
         net_q  <= 1'b0;
         hs_q   <= '1;
         vs_q   <= '1;
         rgb_q  <= '0;
      end else begin
         disp_q <= display_on_i;
         net_q  <= net_d;
         hs_q   <= {hs_q[RENDER_LATENCY-2:0], hsync_i};
         vs_q   <= {vs_q[RENDER_LATENCY-2:0], vsync_i};
         rgb_q  <= rgb_d;
      end
   end

   assign rgb_o   = rgb_q;
   assign hsync_o = hs_q[RENDER_LATENCY-1];
   assign vsync_o = vs_q[RENDER_LATENCY-1];
endmodule
`default_nettype wire

// File: tb/tb_sprite_renderer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | tb_sprite_renderer : directed bench with a behavioural pixel model  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_sprite_renderer;
   import vga_pkg::*;
   import sprite_pkg::*;

   localparam int NS = DEF_N_SPRITES;
   localparam int VR = SCREEN_V_RES;
`ifdef CENTER_NET_EN
   localparam logic [11:0] NET_EXP = 12'h888;
`else
   localparam logic [11:0] NET_EXP = 12'h000;
`endif

   typedef struct packed {
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
   } out_t;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [X_POS_W-1:0] x   = '0;
   logic [Y_POS_W-1:0] y   = '0;
   logic               de  = 1'b0;
   logic               hs  = 1'b1;
   logic               vs  = 1'b1;
   logic [11:0]        rgb;
   logic               hso;
   logic               vso;
   logic               nf;

   rect_t    drv      [NS];
   rect_t    shadow_m [NS];
   out_t     expq     [$];
   int       passed = 0;
   int       total  = 0;
   int       nf_cnt = 0;

   always #5 clk = ~clk;

   sprite_if spr [NS] ();

   for (genvar g = 0; g < NS; g++) begin : g_drv
      assign spr[g].x_pos  = drv[g].x_pos;
      assign spr[g].y_pos  = drv[g].y_pos;
      assign spr[g].right  = drv[g].right;
      assign spr[g].bottom = drv[g].bottom;
   end

   sprite_renderer dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .x_pos_i      (x),
      .y_pos_i      (y),
      .display_on_i (de),
      .hsync_i      (hs),
      .vsync_i      (vs),
      .sprites_i    (spr),
      .rgb_o        (rgb),
      .hsync_o      (hso),
      .vsync_o      (vso),
      .new_frame_o  (nf)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Pixel colour straight from the rules: blank, sprite, net, background.
   function automatic logic [11:0] model_pix(input int px, input int py, input bit pde);
      if (!pde) return 12'h000;
      for (int i = 0; i < NS; i++)
         if (px >= int'(shadow_m[i].x_pos) && px < int'(shadow_m[i].right) &&
             py >= int'(shadow_m[i].y_pos) && py < int'(shadow_m[i].bottom))
            return 12'hFFF;
`ifdef CENTER_NET_EN
      if ((px == SCREEN_H_RES/2 - 1 || px == SCREEN_H_RES/2) && py[3] == 1'b0) return 12'h888;
`endif
      return 12'h000;
   endfunction

   task automatic step(input int px, input int py, input bit pde,
                       input bit phs, input bit pvs, input bit prst);
      out_t e;
      x = X_POS_W'(px); y = Y_POS_W'(py); de = pde; hs = phs; vs = pvs; rst = prst;
      #1;
      check("new_frame", 32'(nf), 32'(!prst && px == 0 && py == VR));
      if (nf) nf_cnt++;
      if (prst) begin
         expq.delete();
         for (int i = 0; i < NS; i++) shadow_m[i] = '0;
         expq.push_back(out_t'{rgb: 12'h000, hs: 1'b1, vs: 1'b1});
      end else begin
         expq.push_back(out_t'{rgb: model_pix(px, py, pde), hs: phs, vs: pvs});
         if (px == 0 && py == VR + 1)
            for (int i = 0; i < NS; i++) shadow_m[i] = drv[i];
      end
      @(posedge clk); #1;
      if (prst) begin
         check("reset_outputs", 32'({rgb, hso, vso, nf}), 32'({12'h000, 1'b1, 1'b1, 1'b0}));
      end else if (expq.size() >= 2) begin
         e = expq.pop_front();
         check("pipeline", 32'({rgb, hso, vso}), 32'(e));
      end
   endtask

   task automatic idle(input int py);
      step(700, py, 1'b0, 1'b1, 1'b1, 1'b0);
   endtask

   // Apply one pixel, flush it to the output, and pin the colour to a literal.
   task automatic probe(input string name, input int px, input int py, input bit pde,
                        input logic [11:0] lit);
      step(px, py, pde, 1'b1, 1'b1, 1'b0);
      idle(0);
      check(name, 32'(rgb), 32'(lit));
   endtask

   task automatic frame_load();
      step(0, VR,     1'b0, 1'b1, 1'b1, 1'b0);
      step(0, VR + 1, 1'b0, 1'b1, 1'b1, 1'b0);
   endtask

   initial begin
      int hs_low;
      for (int i = 0; i < NS; i++) drv[i] = '0;
      @(posedge clk); #1;

      step(5, 5, 1'b1, 1'b0, 1'b0, 1'b1);
      step(0, VR, 1'b1, 1'b1, 1'b1, 1'b1);
      step(1, 1, 1'b1, 1'b1, 1'b1, 1'b1);
      probe("no_sprite_before_load", 10, 20, 1'b1, 12'h000);

      drv[0] = '{10'd10, 10'd20, 10'd14, 10'd24};
      frame_load();
      probe("sprite_top_left",  10, 20, 1'b1, 12'hFFF);
      probe("sprite_bot_right", 13, 23, 1'b1, 12'hFFF);
      probe("right_exclusive",  14, 20, 1'b1, 12'h000);
      probe("bottom_exclusive", 10, 24, 1'b1, 12'h000);
      probe("left_outside",      9, 20, 1'b1, 12'h000);
      probe("display_off",      10, 20, 1'b0, 12'h000);

      hs_low = 0;
      for (int px = 640; px < 800; px++) begin
         step(px, 30, 1'b0, !(px >= 656 && px < 752), 1'b1, 1'b0);
         if (!hso) hs_low++;
      end
      for (int k = 0; k < 2; k++) begin
         idle(30);
         if (!hso) hs_low++;
      end
      check("hsync_low_cycles", 32'(hs_low), 32'd96);

      step(0, 100, 1'b1, 1'b1, 1'b1, 1'b0);
      drv[0] = '{10'd200, 10'd100, 10'd210, 10'd110};
      probe("old_shadow_held", 12, 22, 1'b1, 12'hFFF);
      probe("new_not_yet",    205, 105, 1'b1, 12'h000);
      step(0, VR, 1'b0, 1'b1, 1'b1, 1'b0);
      probe("still_old_at_vres", 12, 22, 1'b1, 12'hFFF);
      step(0, VR + 1, 1'b0, 1'b1, 1'b1, 1'b0);
      probe("new_after_load", 205, 105, 1'b1, 12'hFFF);
      probe("old_gone",        12,  22, 1'b1, 12'h000);

      drv[0] = '{10'd0, 10'd470, 10'd4, 10'd490};
      frame_load();
      drv[0] = '{10'd300, 10'd300, 10'd301, 10'd301};
      probe("load_cycle_uses_old", 0, VR + 1, 1'b1, 12'hFFF);
      probe("after_load_uses_new", 1, VR + 1, 1'b1, 12'h000);

      drv[0] = '{10'd30, 10'd30, 10'd40, 10'd40};
      drv[1] = '{10'd50, 10'd30, 10'd50, 10'd40};
      drv[2] = '{10'd35, 10'd35, 10'd45, 10'd45};
      frame_load();
      probe("degenerate",      50, 35, 1'b1, 12'h000);
      probe("overlap_0_2",     37, 37, 1'b1, 12'hFFF);
      probe("sprite2_only",    42, 42, 1'b1, 12'hFFF);
      probe("net_x320_y0",    320,  0, 1'b1, NET_EXP);
      probe("net_x319_y0",    319,  0, 1'b1, NET_EXP);
      probe("net_x320_y8",    320,  8, 1'b1, 12'h000);
      probe("net_x321_y0",    321,  0, 1'b1, 12'h000);

      nf_cnt = 0;
      for (int py = VR - 1; py <= VR + 2; py++)
         for (int px = 0; px < 3; px++)
            step(px, py, 1'b0, 1'b1, 1'b1, 1'b0);
      check("new_frame_pulses", 32'(nf_cnt), 32'd1);

      step(100, 35, 1'b1, 1'b1, 1'b1, 1'b0);
      step(101, 35, 1'b1, 1'b0, 1'b0, 1'b1);
      probe("black_after_reset", 37, 37, 1'b1, 12'h000);
      frame_load();
      probe("sprite_after_reload", 37, 37, 1'b1, 12'hFFF);

      idle(0);
      idle(0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
`default_nettype wire
